// File: rtl/hd_pkg.sv
// Shared types and constants for the HD-CPU beat sequencer.
// Beat encodings are the one-hot W patterns that the hardwired controller decodes.
package hd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } state_t;

  localparam logic [2:0] W_NONE = 3'b000;
  localparam logic [2:0] W_B1   = 3'b001;
  localparam logic [2:0] W_B2   = 3'b010;
  localparam logic [2:0] W_B3   = 3'b100;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 16;

  function automatic logic [2:0] beat_of(state_t s);
    logic [2:0] w;
    w = W_NONE;
    case (s)
      B1:      w = W_B1;
      B2:      w = W_B2;
      B3:      w = W_B3;
      default: w = W_NONE;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/hd_key_sync.sv
// Front-panel start key synchroniser with a single-cycle rising-edge pulse.
// A held key produces exactly one pulse; a new press needs the key to drop first.
module hd_key_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic t3,
  input  logic clr,
  input  logic qd,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge t3 or negedge clr) begin
    if (!clr) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], qd};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/hd_beat_ctrl.sv
// Machine-cycle beat sequencer: one-hot W beats, SHORT/LONG/STOP handling,
// console ST0 flag, start/halt from the key, and a completed-cycle counter.
//
// state | meaning
// IDLE  | halted, W=000, waiting for a key press
// B1    | first beat, W=001
// B2    | second beat, W=010
// B3    | third beat (LONG cycles only), W=100
module hd_beat_ctrl
  import hd_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             T3,
  input  logic             CLR,
  input  logic             QD,
  input  logic             STEP,
  input  logic [2:0]       SW,
  input  logic             SHORT,
  input  logic             LONG,
  input  logic             STOP,
  input  logic             SST0,
  output logic [2:0]       W,
  output logic             ST0,
  output logic             RUN,
  output logic [CNT_W-1:0] CYCLES
);

  state_t           state_q, state_d;
  logic             press;
  logic             last_beat;
  logic             halt;
  logic             sw_chg;
  logic             cycle_done;
  logic             st0_q;
  logic [2:0]       sw_q;
  logic [CNT_W-1:0] cycles_q;

  hd_key_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_key_sync (
    .t3   (T3),
    .clr  (CLR),
    .qd   (QD),
    .press(press)
  );

  assign sw_chg = (SW != sw_q);
  assign halt   = STOP | STEP;

  // SHORT/LONG are re-read in every beat, so a B2 with SHORT set also ends the cycle.
  always_comb begin
    last_beat = 1'b0;
    case (state_q)
      B1:      last_beat = SHORT;
      B2:      last_beat = SHORT | ~LONG;
      B3:      last_beat = 1'b1;
      default: last_beat = 1'b0;
    endcase
  end

  assign cycle_done = last_beat & ~sw_chg;

  always_ff @(posedge T3 or negedge CLR) begin
    if (!CLR) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sw_chg) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (press) state_d = B1;
        B1:   state_d = last_beat ? (halt ? IDLE : B1) : B2;
        B2:   state_d = last_beat ? (halt ? IDLE : B1) : B3;
        B3:   state_d = halt ? IDLE : B1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    W   = W_NONE;
    RUN = 1'b0;
    W   = beat_of(state_q);
    RUN = (state_q != IDLE);
  end

  // A console mode change clears ST0 even if the controller asks to set it.
  always_ff @(posedge T3 or negedge CLR) begin
    if (!CLR) begin
      st0_q <= 1'b0;
      sw_q  <= 3'b000;
    end else begin
      sw_q <= SW;
      if (sw_chg)
        st0_q <= 1'b0;
      else if (SST0 && state_q != IDLE)
        st0_q <= 1'b1;
    end
  end

  always_ff @(posedge T3 or negedge CLR) begin
    if (!CLR)            cycles_q <= '0;
    else if (cycle_done) cycles_q <= cycles_q + CNT_W'(1);
  end

  assign ST0    = st0_q;
  assign CYCLES = cycles_q;

endmodule

// File: doc/hd_beat_ctrl.md
# hd_beat_ctrl

Beat/timing sequencer for the HD-CPU hardwired controller. It generates the one-hot machine-cycle beats W[3:1] that the controller decodes, and honours the controller's SHORT, LONG and STOP requests. It owns the console phase flag ST0 and starts or halts execution from the front-panel start key. It sits between the console (QD, SW, STEP) and the controller, replacing any ad-hoc ST0/SST0 latching inside the controller.

## Interface
- SYNC_STAGES, 2, number of synchroniser flops on QD (≥2)
- CNT_W, 16, width of the completed-cycle counter

- T3  in  1  clock; all state updates on rising edge
- CLR  in  1  reset; asynchronous, active-low
- QD  in  1  start key, asynchronous level, active-high
- STEP  in  1  single-step mode: halt after every machine cycle
- SW  in  3  console mode switches (synchronous to T3)
- SHORT  in  1  from controller: current cycle ends after W1
- LONG  in  1  from controller: current cycle extends to W3
- STOP  in  1  from controller: halt after current cycle
- SST0  in  1  from controller: set ST0 at end of current beat
- W  out  3  one-hot beat (W[1]=bit0); 000 when idle
- ST0  out  1  console phase flag
- RUN  out  1  1 while a beat is active
- CYCLES  out  CNT_W  count of completed machine cycles

## Operation
- Reset values: W=000, ST0=0, RUN=0, CYCLES=0, synchroniser and SW-history flops 0, state IDLE.
- States: IDLE, B1, B2, B3. W is decoded from state (IDLE→000, B1→001, B2→010, B3→100); RUN = (state≠IDLE).
- Last beat: B1 if SHORT; else B2 if !LONG; else B3. SHORT beats LONG. SHORT/LONG are sampled in the beat being ended, so B2/B3 re-evaluate them.
- IDLE: on a QD rising-edge pulse → B1. Otherwise stay.
- Non-last beat: B1→B2, B2→B3.
- Last beat: CYCLES+1, wrapping at 2^CNT_W−1→0.
  - If STOP or STEP → IDLE.
  - Else → B1 (free run).
- STOP is ignored in non-last beats.
- QD pulses while RUN=1 are ignored, including a pulse coincident with the last beat. A new press is required after returning to IDLE.
- ST0: set to 1 at the end of any active beat with SST0=1. It is never cleared by SST0=0.
- SW change: when SW differs from its registered copy, on that edge:
  - ST0←0 and state←IDLE.
  - This overrides SST0 and any advance/start in the same cycle.
  - CYCLES is not incremented for the aborted cycle.
- SST0 in IDLE has no effect.
- CLR mid-cycle immediately forces all reset values; W drops without waiting for a beat boundary.

## Timing
- Start latency: QD sampled high at edge k gives W=001 after edge k+SYNC_STAGES (SYNC_STAGES+1 edges including k). The edge detect is synchroniser output & !previous.
- Each beat lasts exactly one T3 period. A SHORT cycle is 1 period, normal 2, LONG 3.
- Free-run: no idle gap; B1 follows the last beat on the next edge.
- ST0 and CYCLES update on the same edge that ends the beat/cycle; visible to the controller in the next beat.
- SW abort takes effect on the first edge at which the new SW value is sampled; W=000 from that edge.

## Structure
- Package hd_pkg:
  - state enum (IDLE, B1, B2, B3)
  - beat constants W_NONE=000, W_B1=001, W_B2=010, W_B3=100
  - default parameter constants
- Sub-module hd_key_sync: SYNC_STAGES-deep synchroniser plus single-cycle rising-edge pulse. Resets to 0 on CLR.
- Top holds the FSM, the ST0 flag, the SW history register and the CYCLES counter.

## Test plan
- Reset: hold CLR=0 with QD=1, SST0=1 → W=000, ST0=0, RUN=0, CYCLES=0. Release CLR, QD held high → exactly one start, W=001 after 3 edges.
- Cycle lengths, STEP=1: SHORT=1 → W 001 then 000; LONG=1 → 001,010,100,000; LONG=1 with SHORT=1 → 001,000; neither → 001,010,000. CYCLES counts 1 per cycle.
- Free run, STEP=0: LONG=0, STOP asserted only in the 4th cycle → W sequence 001,010 ×4, then 000; CYCLES=4. STOP pulsed in B1 of a 2-beat cycle → no halt.
- ST0: SW=001, SHORT=1, SST0=1 in the first cycle → ST0=1 after that edge and stays 1 through later cycles with SST0=0. Change SW to 010 in the same edge as SST0=1 → ST0=0, W=000.
- Key handling: QD pulse while RUN=1 → no extra cycle. CNT_W=4, run 17 cycles → CYCLES wraps to 1.
- Async reset in B2 of a LONG cycle → W=000 immediately, before the next T3 edge.
